// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that drains bytes from a synchronous FIFO read port.
// Frame: start, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_parity;
    logic        w_parity_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_bit_end;

    assign w_bit_end = (r_baud == LP_BAUD_LAST);
    assign tx        = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    // w_tx_next is the line level for the state being entered, so the
    // registered tx lines up with the state without an input-to-output path.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_tx_next      = 1'b1;
        fifo_rd        = 1'b0;
        busy           = (r_state != S_IDLE);
        frame_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd      = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_shift_next   = fifo_data;
                w_parity_next  = ^fifo_data;
                w_bit_idx_next = 3'd0;
                w_tx_next      = 1'b0;
                w_state_next   = S_START;
            end
            S_START: begin
                w_tx_next   = 1'b0;
                w_baud_next = r_baud + 16'd1;
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next   = r_shift[0];
                w_baud_next = r_baud + 16'd1;
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = 3'd0;
                        if (PARITY_EN != 0) begin
                            w_tx_next    = r_parity;
                            w_state_next = S_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                w_tx_next   = r_parity;
                w_baud_next = r_baud + 16'd1;
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                w_baud_next = r_baud + 16'd1;
                if (w_bit_end) begin
                    frame_done   = 1'b1;
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx (one no-parity and one parity instance).
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        string      exp_np;
        string      exp_p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en    [2];
    logic       empty [2];
    logic [7:0] fdata [2];
    logic       rd    [2];
    logic       txl   [2];
    logic       busy  [2];
    logic       done  [2];

    logic [7:0] mem [2][256];
    int         wp  [2];
    int         rp  [2];
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;

    int          idle_from [2];
    int          rd_cyc    [2];
    int          fs        [2];
    logic [10:0] fbits     [2];

    logic  in_fr [2];
    int    fall  [2];
    string cur   [2];
    string hist  [2][128];
    int    hlen  [2][128];
    int    hfall [2][128];
    int    nd    [2];

    vec_t vecs [8];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut_np (
        .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(fdata[0]),
        .fifo_rd(rd[0]), .tx(txl[0]), .busy(busy[0]), .frame_done(done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_p (
        .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(fdata[1]),
        .fifo_rd(rd[1]), .tx(txl[1]), .busy(busy[1]), .frame_done(done[1])
    );

    assign empty[0] = (wp[0] == rp[0]);
    assign empty[1] = (wp[1] == rp[1]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rd[k] && wp[k] != rp[k]) begin
                fdata[k] <= mem[k][rp[k] & 255];
                rp[k]    <= rp[k] + 1;
            end
        end
    end

    // Bit k of the result is the k-th bit placed on the line.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic par);
        if (par) return {1'b1, ^d, d, 1'b0};
        return {2'b01, d, 1'b0};
    endfunction

    // Reference: a qualifying idle cycle c schedules the read at c+1, the start bit at c+3.
    always @(negedge clk) begin : model
        logic [3:0] got;
        logic [3:0] want;
        int off;
        int nb;
        for (int k = 0; k < 2; k++) begin
            nb = (k == 1) ? 11 : 10;
            if (rst) begin
                want         = 4'b1000;
                idle_from[k] = cyc + 1;
                rd_cyc[k]    = -1;
                fs[k]        = -100000;
            end else begin
                off     = cyc - fs[k];
                want[3] = (off >= 0 && off < nb * CPB) ? fbits[k][off / CPB] : 1'b1;
                want[2] = (cyc == rd_cyc[k]);
                want[1] = (cyc < idle_from[k]);
                want[0] = (off == nb * CPB - 1);
                if (cyc >= idle_from[k] && en[k] && !empty[k]) begin
                    fbits[k]     = frame_of(mem[k][rp[k] & 255], k == 1);
                    rd_cyc[k]    = cyc + 1;
                    fs[k]        = cyc + 3;
                    idle_from[k] = cyc + 3 + nb * CPB;
                end
            end
            got = {txl[k], rd[k], busy[k], done[k]};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cycle-model cyc=%0d dut%0d {tx,rd,busy,done} got %b expected %b",
                         cyc, k, got, want);
            end
        end
    end

    always @(negedge clk) begin : decoder
        int off;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                in_fr[k] = 1'b0;
            end else begin
                if (!in_fr[k] && !txl[k]) begin
                    in_fr[k] = 1'b1;
                    fall[k]  = cyc;
                    cur[k]   = "";
                end
                if (in_fr[k]) begin
                    off = cyc - fall[k];
                    if (off % CPB == CPB / 2) cur[k] = $sformatf("%s%0d", cur[k], txl[k]);
                    if (done[k]) begin
                        if (nd[k] < 128) begin
                            hist[k][nd[k]]  = cur[k];
                            hlen[k][nd[k]]  = off + 1;
                            hfall[k][nd[k]] = fall[k];
                        end
                        nd[k]++;
                        in_fr[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wp[k] & 255] = d;
        wp[k]++;
    endtask

    task automatic push_both(input logic [7:0] d);
        push(0, d);
        push(1, d);
    endtask

    task automatic set_en(input logic v);
        en[0] = v;
        en[1] = v;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic wait_nd(input int target, input int budget);
        int n = 0;
        while ((nd[0] < target || nd[1] < target) && n < budget) begin
            step(1);
            n++;
        end
        chk("frame wait in budget", int'(nd[0] >= target && nd[1] >= target), 1);
    endtask

    task automatic wait_rd(input int budget);
        int n = 0;
        while (!rd[0] && n < budget) begin
            step(1);
            n++;
        end
        chk("read strobe wait in budget", int'(rd[0]), 1);
    endtask

    task automatic check_frame(input int vi, input int h);
        chk_s("frame bits no-parity", hist[0][h], vecs[vi].exp_np);
        chk_s("frame bits parity", hist[1][h], vecs[vi].exp_p);
        chk("frame length no-parity", hlen[0][h], 10 * CPB);
        chk("frame length parity", hlen[1][h], 11 * CPB);
    endtask

    task automatic set_vec(input int i, input logic [7:0] d, input string np, input string p);
        vecs[i].data   = d;
        vecs[i].exp_np = np;
        vecs[i].exp_p  = p;
    endtask

    initial begin
        int base;
        int n;
        set_vec(0, 8'hA5, "0101001011", "01010010101");
        set_vec(1, 8'h07, "0111000001", "01110000011");
        set_vec(2, 8'h01, "0100000001", "01000000011");
        set_vec(3, 8'h80, "0000000011", "00000000111");
        set_vec(4, 8'hFF, "0111111111", "01111111101");
        set_vec(5, 8'h3C, "0001111001", "00011110001");
        set_vec(6, 8'h55, "0101010101", "01010101001");
        set_vec(7, 8'h22, "0010001001", "00100010001");

        set_en(1'b1);
        push_both(vecs[0].data);
        step(4);
        for (int k = 0; k < 2; k++) begin
            chk("reset tx", int'(txl[k]), 1);
            chk("reset fifo_rd", int'(rd[k]), 0);
            chk("reset busy", int'(busy[k]), 0);
        end
        set_en(1'b0);
        rst = 1'b0;
        step(6);
        chk("no read while disabled dut0", rp[0], 0);
        chk("no read while disabled dut1", rp[1], 0);
        set_en(1'b1);
        wait_nd(1, 200);
        check_frame(0, 0);

        for (int i = 1; i < 8; i++) begin
            base = nd[0];
            push_both(vecs[i].data);
            wait_nd(base + 1, 200);
            check_frame(i, base);
        end

        base = nd[0];
        push_both(8'h01);
        push_both(8'h80);
        push_both(8'hFF);
        wait_nd(base + 3, 600);
        for (int j = 0; j < 3; j++) check_frame(2 + j, base + j);
        for (int j = 1; j < 3; j++) begin
            chk("line-high gap no-parity", hfall[0][base + j] - hfall[0][base + j - 1] - 9 * CPB, CPB + 3);
            chk("line-high gap parity", hfall[1][base + j] - hfall[1][base + j - 1] - 10 * CPB, CPB + 3);
        end
        chk("three reads dut0", wp[0] - rp[0], 0);
        chk("three reads dut1", wp[1] - rp[1], 0);

        base = nd[0];
        push_both(8'h3C);
        push_both(8'h55);
        wait_rd(100);
        step(2 + 3 * CPB);
        set_en(1'b0);
        wait_nd(base + 1, 200);
        step(60);
        chk("no read after enable drop dut0", wp[0] - rp[0], 1);
        chk("no read after enable drop dut1", wp[1] - rp[1], 1);
        check_frame(5, base);
        set_en(1'b1);
        wait_nd(base + 2, 200);
        check_frame(6, base + 1);

        base = nd[0];
        push_both(8'h11);
        push_both(8'h22);
        wait_rd(100);
        step(2 + 4 * CPB + 1);
        chk("tx low in D3 dut0", int'(txl[0]), 0);
        chk("tx low in D3 dut1", int'(txl[1]), 0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("tx high at async reset", int'(txl[k]), 1);
            chk("busy low at async reset", int'(busy[k]), 0);
        end
        step(2);
        rst = 1'b0;
        wait_nd(base + 1, 200);
        check_frame(7, base);
        chk("following entry read dut0", wp[0] - rp[0], 0);
        chk("following entry read dut1", wp[1] - rp[1], 0);

        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 9) == 0 && (wp[k] - rp[k]) < 8) push(k, 8'($urandom));
                if ($urandom_range(0, 19) == 0) en[k] = ~en[k];
            end
            step(1);
        end
        set_en(1'b1);
        n = 0;
        while ((!empty[0] || !empty[1] || busy[0] || busy[1]) && n < 4000) begin
            step(1);
            n++;
        end
        chk("random drain in budget", int'(empty[0] && empty[1] && !busy[0] && !busy[1]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains bytes from the 8-bit synchronous FIFO on its read side and sends each one as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits directly downstream of the FIFO. It issues single-cycle read strobes only when the FIFO reports non-empty, and captures the FIFO's registered output one cycle later. Baud timing comes from an internal clock divider.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 0 = no parity bit (10-bit frame); 1 = even parity bit after D7 (11-bit frame).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data; valid the cycle after the fifo_rd cycle.
- fifo_rd  output  1  FIFO read strobe; one cycle per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever the state is not IDLE.
- frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- Reset values: state IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, shift register 0, counters 0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE -> FETCH when enable=1 and fifo_empty=0; otherwise hold.
- FETCH: fifo_rd=1 for exactly this cycle (Moore output, state==FETCH); always -> LOAD.
- LOAD: shift register <= fifo_data; parity bit <= XOR of fifo_data; -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right; after bit 7, -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: tx=even-parity bit for CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the last cycle -> IDLE.
- tx is registered: it is driven from the state and shift register with no combinational path from inputs.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change. Bit index is 3 bits, 0..7.
- fifo_rd is never asserted outside FETCH, so at most one read per frame and no read while empty.
- enable low mid-frame: the current frame completes; no new FETCH.
- fifo_empty is ignored outside IDLE.
- Reset mid-frame: tx goes to 1 immediately (async); the byte in flight is discarded and not re-read.

## Timing
- Edge E0 samples IDLE, enable=1, fifo_empty=0 -> fifo_rd high in cycle E0..E1, LOAD in E1..E2, tx falls at E2.
- Start-bit leading edge is 2 clk cycles after the read-strobe rising edge.
- Frame length: 10*CLKS_PER_BIT cycles (PARITY_EN=0) or 11*CLKS_PER_BIT cycles (PARITY_EN=1), measured from the tx fall to the STOP exit.
- Back-to-back bytes: the line stays high for CLKS_PER_BIT+3 cycles between consecutive start bits (stop bit + IDLE + FETCH + LOAD).
- busy rises the cycle after the qualifying IDLE sample and falls the cycle after frame_done.

## Test plan
- Reset: assert rst with FIFO non-empty -> tx=1, fifo_rd=0, busy=0; no read until rst is released and enable=1.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0 -> exactly one fifo_rd pulse; tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame_done pulses once, 40 cycles after the tx fall.
- PARITY_EN=1, bytes 0x07 then 0xA5 -> parity bits 1 then 0; each frame 44 cycles at CLKS_PER_BIT=4.
- FIFO holds 3 bytes (0x01, 0x80, 0xFF), enable held high -> exactly 3 fifo_rd pulses; 7-cycle high gaps between frames at CLKS_PER_BIT=4; no read once fifo_empty=1.
- Drop enable during DATA of byte 0x3C -> frame completes correctly; no further fifo_rd while enable=0; transmission resumes one frame after enable returns.
- Assert rst during bit D3 -> tx=1 in the same cycle, busy=0; after release, the next byte read is the following FIFO entry.
